// File: rtl/mips_mc_pkg.sv
// Shared definitions for the multi-cycle MIPS core: opcodes, functs,
// sequencer states and the ALU operation encoding.
package mips_mc_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        EXEC_R,
        EXEC_I,
        MEM_ADDR,
        MEM_RD,
        MEM_WR,
        WB_R,
        WB_I,
        WB_MEM,
        BRANCH,
        JUMP,
        HALT
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT,
        ALU_LUI
    } alu_op_t;

    // Single shared ALU; LUI takes its immediate from the low half of b.
    function automatic logic [31:0] alu_calc(input alu_op_t op,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
        logic [31:0] r;
        r = 32'h0000_0000;
        case (op)
            ALU_ADD: r = a + b;
            ALU_SUB: r = a - b;
            ALU_AND: r = a & b;
            ALU_OR:  r = a | b;
            ALU_SLT: r = ($signed(a) < $signed(b)) ? 32'h0000_0001 : 32'h0000_0000;
            ALU_LUI: r = {b[15:0], 16'h0000};
            default: r = 32'h0000_0000;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mips_mc_regfile.sv
// 32x32 register file: two asynchronous read ports, one synchronous write
// port, asynchronous clear; register 0 always reads zero.
module mips_mc_regfile (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    output logic [31:0] rd1,
    output logic [31:0] rd2,
    input  logic        we,
    input  logic [4:0]  wa,
    input  logic [31:0] wd
);

    logic [31:0] regs [32];

    // Write port; writes aimed at register 0 are dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= 32'h0000_0000;
            end
        end else if (we && (wa != 5'd0)) begin
            regs[wa] <= wd;
        end
    end

    assign rd1 = (ra1 == 5'd0) ? 32'h0000_0000 : regs[ra1];
    assign rd2 = (ra2 == 5'd0) ? 32'h0000_0000 : regs[ra2];

endmodule

// File: rtl/mips_mc_core.sv
// Multi-cycle MIPS core: one sequencer drives a shared datapath
// (IR, A, B, ALUOut, MDR) over a single req/ready memory port.
module mips_mc_core
    import mips_mc_pkg::*;
#(
    parameter int          ADDR_W   = 12,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic              wb_en,
    output logic [4:0]        wb_addr,
    output logic [31:0]       wb_data,
    output logic              retire,
    output logic              halted,
    output logic [31:0]       pc_o
);

    state_t      state;
    state_t      next_state;
    logic [31:0] pc;
    logic [31:0] ir;
    logic [31:0] reg_a;
    logic [31:0] reg_b;
    logic [31:0] alu_out;
    logic [31:0] mdr;

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] imm_sext;
    logic [31:0] imm_zext;
    logic [31:0] mem_sum;
    logic [31:0] rs_data;
    logic [31:0] rt_data;

    alu_op_t     r_op;
    logic        r_legal;
    alu_op_t     i_op;
    logic [31:0] i_operand;

    logic        req_state;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    assign opcode   = ir[31:26];
    assign rs       = ir[25:21];
    assign rt       = ir[20:16];
    assign rd       = ir[15:11];
    assign funct    = ir[5:0];
    assign imm_sext = {{16{ir[15]}}, ir[15:0]};
    assign imm_zext = {16'h0000, ir[15:0]};
    assign mem_sum  = reg_a + imm_sext;

    mips_mc_regfile u_regfile (
        .clk (clk),
        .rst (rst),
        .ra1 (rs),
        .ra2 (rt),
        .rd1 (rs_data),
        .rd2 (rt_data),
        .we  (wb_en),
        .wa  (rf_waddr),
        .wd  (rf_wdata)
    );

    // R-type funct decode; anything unlisted is illegal.
    always_comb begin
        r_op    = ALU_ADD;
        r_legal = 1'b1;
        case (funct)
            FN_ADDU: r_op = ALU_ADD;
            FN_SUBU: r_op = ALU_SUB;
            FN_AND:  r_op = ALU_AND;
            FN_OR:   r_op = ALU_OR;
            FN_SLT:  r_op = ALU_SLT;
            default: r_legal = 1'b0;
        endcase
    end

    // I-type operation and immediate extension select.
    always_comb begin
        i_op      = ALU_ADD;
        i_operand = imm_sext;
        case (opcode)
            OP_ORI: begin
                i_op      = ALU_OR;
                i_operand = imm_zext;
            end
            OP_LUI: begin
                i_op      = ALU_LUI;
                i_operand = imm_zext;
            end
            default: begin
                i_op      = ALU_ADD;
                i_operand = imm_sext;
            end
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FETCH;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic and per-state control outputs.
    always_comb begin
        next_state = state;
        req_state  = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = pc[ADDR_W-1:0];
        rf_we      = 1'b0;
        rf_waddr   = rt;
        rf_wdata   = alu_out;
        retire     = 1'b0;
        halted     = 1'b0;
        case (state)
            FETCH: begin
                req_state  = 1'b1;
                next_state = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                case (opcode)
                    OP_RTYPE:                 next_state = r_legal ? EXEC_R : HALT;
                    OP_ADDIU, OP_ORI, OP_LUI: next_state = EXEC_I;
                    OP_LW, OP_SW:             next_state = MEM_ADDR;
                    OP_BEQ:                   next_state = BRANCH;
                    OP_J:                     next_state = JUMP;
                    default:                  next_state = HALT;
                endcase
            end
            EXEC_R: next_state = WB_R;
            EXEC_I: next_state = WB_I;
            WB_R: begin
                rf_we      = 1'b1;
                rf_waddr   = rd;
                retire     = 1'b1;
                next_state = FETCH;
            end
            WB_I: begin
                rf_we      = 1'b1;
                retire     = 1'b1;
                next_state = FETCH;
            end
            MEM_ADDR: begin
                if (mem_sum[1:0] != 2'b00) begin
                    next_state = HALT;
                end else if (opcode == OP_LW) begin
                    next_state = MEM_RD;
                end else begin
                    next_state = MEM_WR;
                end
            end
            MEM_RD: begin
                req_state  = 1'b1;
                mem_addr   = alu_out[ADDR_W-1:0];
                next_state = mem_ready ? WB_MEM : MEM_RD;
            end
            WB_MEM: begin
                rf_we      = 1'b1;
                rf_wdata   = mdr;
                retire     = 1'b1;
                next_state = FETCH;
            end
            MEM_WR: begin
                req_state  = 1'b1;
                mem_we     = 1'b1;
                mem_addr   = alu_out[ADDR_W-1:0];
                retire     = mem_ready;
                next_state = mem_ready ? FETCH : MEM_WR;
            end
            BRANCH, JUMP: begin
                retire     = 1'b1;
                next_state = FETCH;
            end
            HALT: begin
                halted     = 1'b1;
                next_state = HALT;
            end
            default: next_state = HALT;
        endcase
    end

    // Architectural datapath registers, loaded per sequencer state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc      <= RESET_PC;
            ir      <= 32'h0000_0000;
            reg_a   <= 32'h0000_0000;
            reg_b   <= 32'h0000_0000;
            alu_out <= 32'h0000_0000;
            mdr     <= 32'h0000_0000;
        end else begin
            case (state)
                FETCH: begin
                    if (mem_ready) begin
                        ir <= mem_rdata;
                        pc <= pc + 32'd4;
                    end
                end
                DECODE: begin
                    reg_a   <= rs_data;
                    reg_b   <= rt_data;
                    alu_out <= pc + {imm_sext[29:0], 2'b00};
                end
                EXEC_R:   alu_out <= alu_calc(r_op, reg_a, reg_b);
                EXEC_I:   alu_out <= alu_calc(i_op, reg_a, i_operand);
                MEM_ADDR: alu_out <= mem_sum;
                MEM_RD: begin
                    if (mem_ready) begin
                        mdr <= mem_rdata;
                    end
                end
                BRANCH: begin
                    if (reg_a == reg_b) begin
                        pc <= alu_out;
                    end
                end
                JUMP:     pc <= {pc[31:28], ir[25:0], 2'b00};
                default: ;
            endcase
        end
    end

    // Request is held low during reset so an abandoned access drops at once.
    assign mem_req   = req_state & ~rst;
    assign mem_wdata = reg_b;
    assign wb_en     = rf_we & (rf_waddr != 5'd0);
    assign wb_addr   = rf_waddr;
    assign wb_data   = rf_wdata;
    assign pc_o      = pc;

endmodule

// File: tb/tb_mips_mc_core.sv
// Scoreboard bench for mips_mc_core: an ISA-level reference model predicts
// writebacks, stores, next PCs and cycle counts; a monitor checks the DUT.
module tb_mips_mc_core;

    localparam int          ADDR_W   = 12;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata = 32'h0;
    logic              mem_ready = 1'b0;
    logic              wb_en;
    logic [4:0]        wb_addr;
    logic [31:0]       wb_data;
    logic              retire;
    logic              halted;
    logic [31:0]       pc_o;

    always #5 clk = ~clk;

    mips_mc_core #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .wb_en(wb_en), .wb_addr(wb_addr),
        .wb_data(wb_data), .retire(retire), .halted(halted), .pc_o(pc_o)
    );

    typedef struct packed { logic [4:0] a; logic [31:0] d; } wb_t;
    typedef struct packed { logic [11:0] a; logic [31:0] d; } st_t;
    typedef struct packed { logic [31:0] npc; logic [31:0] lat; } ret_t;

    logic [31:0] mem  [0:1023];
    logic [31:0] mmem [0:1023];
    logic [31:0] mreg [0:31];
    wb_t  wb_q[$];
    st_t  st_q[$];
    ret_t ret_q[$];
    int   halt_lat;
    int   checks = 0;
    int   errors = 0;
    int   max_wait = 0;
    bit   rand_wait = 1'b0;
    bit   stall_data = 1'b0;
    bit   mon_en = 1'b1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [5:0] fn, input logic [4:0] rd,
                                          input logic [4:0] rs, input logic [4:0] rt);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rt,
                                          input logic [4:0] rs, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    // ISA-level reference: executes the program in mmem and queues expectations.
    task automatic model_run();
        logic [31:0] pc, w, a, b, res, nxt, ea, simm;
        logic [5:0]  op, fn;
        logic [4:0]  dst;
        int          lat;
        bit          done;
        wb_t e_wb;
        st_t e_st;
        ret_t e_rt;
        for (int k = 0; k < 32; k++) mreg[k] = 32'h0;
        for (int k = 0; k < 1024; k++) mmem[k] = mem[k];
        pc = RESET_PC;
        halt_lat = -1;
        done = 1'b0;
        for (int n = 0; n < 2000 && !done; n++) begin
            w    = mmem[pc[11:2]];
            op   = w[31:26];
            fn   = w[5:0];
            a    = mreg[w[25:21]];
            b    = mreg[w[20:16]];
            simm = {{16{w[15]}}, w[15:0]};
            nxt  = pc + 32'd4;
            dst  = 5'd0;
            res  = 32'h0;
            lat  = 0;
            case (op)
                6'h00: begin
                    lat = 4;
                    dst = w[15:11];
                    case (fn)
                        6'h21: res = a + b;
                        6'h23: res = a - b;
                        6'h24: res = a & b;
                        6'h25: res = a | b;
                        6'h2A: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                        default: begin done = 1'b1; halt_lat = 3; end
                    endcase
                end
                6'h09: begin lat = 4; dst = w[20:16]; res = a + simm; end
                6'h0D: begin lat = 4; dst = w[20:16]; res = a | {16'h0, w[15:0]}; end
                6'h0F: begin lat = 4; dst = w[20:16]; res = {w[15:0], 16'h0}; end
                6'h23, 6'h2B: begin
                    ea = a + simm;
                    if (ea[1:0] != 2'b00) begin
                        done = 1'b1;
                        halt_lat = 4;
                    end else if (op == 6'h23) begin
                        lat = 5;
                        dst = w[20:16];
                        res = mmem[ea[11:2]];
                    end else begin
                        lat = 4;
                        mmem[ea[11:2]] = b;
                        e_st.a = ea[11:0];
                        e_st.d = b;
                        st_q.push_back(e_st);
                    end
                end
                6'h04: begin lat = 3; if (a == b) nxt = pc + 32'd4 + (simm << 2); end
                6'h02: begin lat = 3; nxt = {nxt[31:28], w[25:0], 2'b00}; end
                default: begin done = 1'b1; halt_lat = 3; end
            endcase
            if (!done) begin
                if (dst != 5'd0) begin
                    mreg[dst] = res;
                    e_wb.a = dst;
                    e_wb.d = res;
                    wb_q.push_back(e_wb);
                end
                e_rt.npc = nxt;
                e_rt.lat = 32'(lat);
                ret_q.push_back(e_rt);
                pc = nxt;
            end
        end
    endtask

    task automatic load_directed();
        for (int k = 0; k < 1024; k++) mem[k] = 32'h0;
        mem[0]     = enc_i(6'h0D, 5'd1, 5'd0, 16'h1234);   // ori   $1,$0,0x1234
        mem[1]     = enc_i(6'h09, 5'd2, 5'd1, 16'hFFFC);   // addiu $2,$1,-4
        mem[2]     = {6'h02, 26'h40};                      // j 0x40 -> 0x100
        mem[12'h40] = enc_i(6'h2B, 5'd2, 5'd0, 16'h0008);  // sw  $2,8($0)
        mem[12'h41] = enc_i(6'h23, 5'd3, 5'd0, 16'h0008);  // lw  $3,8($0)
        mem[12'h42] = enc_i(6'h09, 5'd5, 5'd0, 16'hFFFF);
        mem[12'h43] = enc_i(6'h09, 5'd6, 5'd0, 16'h0001);
        mem[12'h44] = enc_r(6'h2A, 5'd4, 5'd5, 5'd6);      // slt  $4,$5,$6
        mem[12'h45] = enc_r(6'h23, 5'd7, 5'd0, 5'd6);      // subu $7,$0,$6
        mem[12'h46] = enc_r(6'h21, 5'd0, 5'd1, 5'd1);      // addu $0,$1,$1
        mem[12'h47] = enc_i(6'h04, 5'd1, 5'd1, 16'h0002);  // beq taken
        mem[12'h48] = enc_i(6'h0D, 5'd8, 5'd0, 16'h0BAD);
        mem[12'h49] = enc_i(6'h0D, 5'd8, 5'd0, 16'h0BAD);
        mem[12'h4A] = enc_i(6'h04, 5'd2, 5'd1, 16'h0005);  // beq not taken
        mem[12'h4B] = enc_i(6'h0F, 5'd9, 5'd0, 16'hABCD);
        mem[12'h4C] = enc_r(6'h24, 5'd10, 5'd9, 5'd5);
        mem[12'h4D] = enc_r(6'h25, 5'd11, 5'd1, 5'd9);
        mem[12'h4E] = enc_i(6'h23, 5'd12, 5'd0, 16'h0002); // misaligned lw
    endtask

    task automatic load_random();
        logic [5:0]  fn;
        logic [15:0] off;
        int          sel;
        for (int k = 0; k < 1024; k++) mem[k] = 32'h0;
        for (int k = 12'h200; k < 12'h240; k++) mem[k] = $urandom;
        for (int i = 0; i < 39; i++) begin
            sel = $urandom_range(0, 9);
            case ($urandom_range(0, 4))
                0: fn = 6'h21;
                1: fn = 6'h23;
                2: fn = 6'h24;
                3: fn = 6'h25;
                default: fn = 6'h2A;
            endcase
            off = 16'h0800 + 16'($urandom_range(0, 63) * 4);
            if ($urandom_range(0, 24) == 0) off = off + 16'd2;
            case (sel)
                0, 1: mem[i] = enc_r(fn, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
                2: mem[i] = enc_i(6'h09, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom));
                3: mem[i] = enc_i(6'h0D, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom));
                4: mem[i] = enc_i(6'h0F, 5'($urandom_range(0, 7)), 5'd0, 16'($urandom));
                5: mem[i] = enc_i(6'h23, 5'($urandom_range(0, 7)), 5'd0, off);
                6: mem[i] = enc_i(6'h2B, 5'($urandom_range(0, 7)), 5'd0, off);
                7: mem[i] = enc_i(6'h04, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 16'($urandom_range(0, 3)));
                8: mem[i] = {6'h02, 26'(i + 1 + $urandom_range(0, 3))};
                default: mem[i] = ($urandom_range(0, 3) == 0) ? 32'hFC00_0000 : enc_r(6'h21, 5'd3, 5'd1, 5'd2);
            endcase
        end
        mem[39] = 32'hFC00_0000;
    endtask

    task automatic load_after_reset();
        for (int k = 0; k < 1024; k++) mem[k] = 32'h0;
        mem[0] = enc_i(6'h2B, 5'd1, 5'd0, 16'h0804);       // sw   $1,0x804($0)
        mem[1] = enc_r(6'h21, 5'd3, 5'd1, 5'd2);           // addu $3,$1,$2
        mem[2] = enc_r(6'h25, 5'd4, 5'd2, 5'd1);           // or   $4,$2,$1
        mem[3] = 32'hFC00_0000;
    endtask

    // Memory responder: wait states per access, never ready on a stalled address.
    initial begin
        int wcnt, wtarget;
        bit busy;
        busy = 1'b0; wcnt = 0; wtarget = 0;
        forever begin
            @(negedge clk);
            if (rst || !mem_req) begin
                mem_ready = 1'b0;
                busy = 1'b0;
            end else begin
                if (!busy) begin
                    busy = 1'b1;
                    wcnt = 0;
                    wtarget = rand_wait ? $urandom_range(0, max_wait) : max_wait;
                end
                if (!(stall_data && mem_addr == 12'h800) && wcnt >= wtarget) begin
                    mem_ready = 1'b1;
                    if (mem_we) mem[mem_addr[11:2]] = mem_wdata;
                    else        mem_rdata = mem[mem_addr[11:2]];
                    busy = 1'b0;
                end else begin
                    mem_ready = 1'b0;
                    mem_rdata = $urandom;
                    wcnt++;
                end
            end
        end
    end

    int          mon_cyc = 0;
    int          mon_waits = 0;
    bit          pc_chk = 1'b0;
    bit          hseen = 1'b0;
    logic [31:0] pc_exp = 32'h0;

    // Monitor: pops expectations whenever the DUT presents an event.
    initial begin
        wb_t  ew;
        st_t  es;
        ret_t er;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                mon_cyc = 0; mon_waits = 0; pc_chk = 1'b0; hseen = 1'b0;
            end else begin
                mon_cyc++;
                if (mem_req && !mem_ready) mon_waits++;
                if (mon_en) begin
                    if (pc_chk) begin
                        chk("next_pc", 64'(pc_o), 64'(pc_exp));
                        pc_chk = 1'b0;
                    end
                    if (wb_en) begin
                        if (wb_q.size() == 0) begin
                            chk("wb_unexpected", {27'h0, wb_addr, wb_data}, 64'h0);
                        end else begin
                            ew = wb_q.pop_front();
                            chk("writeback", {27'h0, wb_addr, wb_data}, {27'h0, ew.a, ew.d});
                        end
                    end
                    if (mem_req && mem_we && mem_ready) begin
                        if (st_q.size() == 0) begin
                            chk("store_unexpected", {20'h0, mem_addr, mem_wdata}, 64'h0);
                        end else begin
                            es = st_q.pop_front();
                            chk("store", {20'h0, mem_addr, mem_wdata}, {20'h0, es.a, es.d});
                        end
                    end
                    if (retire) begin
                        if (ret_q.size() == 0) begin
                            chk("retire_unexpected", 64'(pc_o), 64'h0);
                        end else begin
                            er = ret_q.pop_front();
                            chk("latency", 64'(mon_cyc), 64'(er.lat) + 64'(mon_waits));
                            pc_exp = er.npc;
                            pc_chk = 1'b1;
                        end
                        mon_cyc = 0;
                        mon_waits = 0;
                    end
                    if (halted && !hseen) begin
                        hseen = 1'b1;
                        chk("halt_latency", 64'(mon_cyc), 64'(halt_lat + mon_waits));
                    end
                end
            end
        end
    end

    task automatic run_phase(input int kind, input int mw, input bit rw);
        int bad;
        @(posedge clk);
        #1 rst = 1'b1;
        #1 chk("reset_outputs", {58'h0, mem_req, mem_we, wb_en, retire, halted, 1'b0},
               64'h0);
        chk("reset_pc", 64'(pc_o), 64'(RESET_PC));
        max_wait = mw;
        rand_wait = rw;
        wb_q.delete(); st_q.delete(); ret_q.delete();
        case (kind)
            0: load_directed();
            1: load_random();
            default: load_after_reset();
        endcase
        model_run();
        mon_en = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        #3 chk("first_fetch", {50'h0, mem_req, mem_we, mem_addr}, {50'h0, 1'b1, 1'b0, RESET_PC[11:0]});
        for (int k = 0; k < 4000; k++) begin
            if (halted) break;
            @(negedge clk);
            #3;
        end
        chk("halt_reached", 64'(halted), 64'h1);
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            #3 if (mem_req) bad++;
        end
        chk("halt_no_req", 64'(bad), 64'h0);
        chk("wb_drained", 64'(wb_q.size()), 64'h0);
        chk("st_drained", 64'(st_q.size()), 64'h0);
        chk("ret_drained", 64'(ret_q.size()), 64'h0);
    endtask

    initial begin
        bit found;
        run_phase(0, 0, 1'b0);
        chk("sw_mem_word", 64'(mem[2]), 64'h1230);
        run_phase(0, 2, 1'b0);
        for (int it = 0; it < 6; it++) begin
            run_phase(1, it % 4, 1'b1);
        end

        // Reset while a load is stalled on the data access.
        @(posedge clk);
        #1 rst = 1'b1;
        mon_en = 1'b0;
        stall_data = 1'b1;
        max_wait = 0;
        rand_wait = 1'b0;
        for (int k = 0; k < 1024; k++) mem[k] = 32'h0;
        mem[0] = enc_i(6'h0D, 5'd1, 5'd0, 16'h5555);
        mem[1] = enc_i(6'h23, 5'd2, 5'd0, 16'h0800);
        @(posedge clk);
        #1 rst = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            #3 if (mem_req && !mem_we && mem_addr == 12'h800) begin
                found = 1'b1;
                break;
            end
        end
        chk("stall_reached", 64'(found), 64'h1);
        repeat (3) @(negedge clk);
        #3 chk("stall_holds", {51'h0, mem_req, mem_addr}, {51'h0, 1'b1, 12'h800});
        @(posedge clk);
        #1 rst = 1'b1;
        #1 chk("rst_drops_req", {60'h0, mem_req, wb_en, retire, halted}, 64'h0);
        stall_data = 1'b0;
        run_phase(2, 1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
